// File: rtl/serial_ctrl_pkg.sv
// Shared constants, state encodings and the frame checksum used by the
// serial command master and its frame parser.
package serial_ctrl_pkg;

  // UART register addresses on the single-bit Avalon address
  localparam logic ADDR_DATA = 1'b0;
  localparam logic ADDR_CTRL = 1'b1;

  // Field positions inside the UART registers
  localparam int RVALID_BIT = 15;
  localparam int WSPACE_LSB = 16;

  // Sync, code, arg_hi, arg_lo, checksum
  localparam int FRAME_LEN = 5;

  typedef enum logic [2:0] {
    BUS_INIT,
    BUS_RD_CTRL,
    BUS_WAIT_CTRL,
    BUS_WR_DATA,
    BUS_RD_DATA,
    BUS_WAIT_DATA
  } bus_state_t;

  typedef enum logic [2:0] {
    P_HUNT,
    P_CODE,
    P_ARG_HI,
    P_ARG_LO,
    P_CHK
  } parse_state_t;

  function automatic logic [7:0] frame_checksum(input logic [7:0] code,
                                                input logic [7:0] arg_hi,
                                                input logic [7:0] arg_lo);
    return code ^ arg_hi ^ arg_lo;
  endfunction

endpackage

// File: rtl/serial_frame_parser.sv
// Turns a stream of received UART bytes into checksummed command frames,
// with an inter-byte idle timeout and a saturating error counter.
module serial_frame_parser
  import serial_ctrl_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 500000,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        byte_valid,
  input  logic [7:0]  rx_byte,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [7:0]  cmd_code,
  output logic [15:0] cmd_arg,
  output logic [7:0]  err_count
);

  localparam logic [19:0] IDLE_LAST = 20'(TIMEOUT_CYCLES - 1);

  parse_state_t state;
  parse_state_t state_next;
  logic [19:0]  idle_cnt;
  logic [7:0]   code_q;
  logic [7:0]   hi_q;
  logic [7:0]   lo_q;
  logic         chk_match;
  logic         chk_fail;
  logic         timeout_hit;

  // Parser state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= P_HUNT;
    else        state <= state_next;
  end

  // Next parser state plus checksum / timeout events; a sync byte mid-frame is plain data
  always_comb begin
    state_next  = state;
    chk_match   = 1'b0;
    chk_fail    = 1'b0;
    timeout_hit = 1'b0;
    if (byte_valid) begin
      case (state)
        P_HUNT:   if (rx_byte == SYNC_BYTE) state_next = P_CODE;
        P_CODE:   state_next = P_ARG_HI;
        P_ARG_HI: state_next = P_ARG_LO;
        P_ARG_LO: state_next = P_CHK;
        P_CHK: begin
          state_next = P_HUNT;
          if (rx_byte == frame_checksum(code_q, hi_q, lo_q)) chk_match = 1'b1;
          else                                               chk_fail  = 1'b1;
        end
        default:  state_next = P_HUNT;
      endcase
    end else if (state != P_HUNT && idle_cnt == IDLE_LAST) begin
      timeout_hit = 1'b1;
      state_next  = P_HUNT;
    end
  end

  // Idle counter only runs while a frame is partially received
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              idle_cnt <= '0;
    else if (byte_valid || state == P_HUNT)  idle_cnt <= '0;
    else                                     idle_cnt <= idle_cnt + 20'd1;
  end

  // Capture the payload bytes as they arrive
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else if (byte_valid) begin
      if (state == P_CODE)   code_q <= rx_byte;
      if (state == P_ARG_HI) hi_q   <= rx_byte;
      if (state == P_ARG_LO) lo_q   <= rx_byte;
    end
  end

  // Present a decoded command and hold it until the consumer takes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_valid <= 1'b0;
      cmd_code  <= '0;
      cmd_arg   <= '0;
    end else if (chk_match) begin
      cmd_valid <= 1'b1;
      cmd_code  <= code_q;
      cmd_arg   <= {hi_q, lo_q};
    end else if (cmd_valid && cmd_ready) begin
      cmd_valid <= 1'b0;
    end
  end

  // Count checksum and timeout errors, sticking at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                          err_count <= '0;
    else if ((chk_fail || timeout_hit) && err_count != 8'hFF) err_count <= err_count + 8'd1;
  end

endmodule

// File: rtl/serial_cmd_master.sv
// Avalon-MM master for the rs232_0 UART: polls CONTROL/DATA, feeds received
// bytes to the frame parser and writes the TX stream when WSPACE allows.
module serial_cmd_master
  import serial_ctrl_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 500000,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  output logic        avm_address,
  output logic        avm_chipselect,
  output logic [3:0]  avm_byteenable,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [7:0]  cmd_code,
  output logic [15:0] cmd_arg,
  output logic [7:0]  err_count
);

  bus_state_t  bus_state;
  bus_state_t  bus_next;
  logic        armed;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic [15:0] wspace;
  logic        unused_readdata;

  assign rx_byte         = avm_readdata[7:0];
  assign wspace          = avm_readdata[WSPACE_LSB +: 16];
  assign unused_readdata = ^avm_readdata[14:8];
  assign avm_chipselect  = avm_read | avm_write;
  assign avm_byteenable  = 4'hF;

  // Hold off the INIT write for one cycle so no strobe is visible during reset
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) armed <= 1'b0;
    else                armed <= 1'b1;
  end

  // Bus FSM state register
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) bus_state <= BUS_INIT;
    else                bus_state <= bus_next;
  end

  // Bus sequencing and single-cycle strobes; TX is served before the RX pop in a loop
  always_comb begin
    bus_next      = bus_state;
    avm_read      = 1'b0;
    avm_write     = 1'b0;
    avm_address   = ADDR_DATA;
    avm_writedata = '0;
    tx_ready      = 1'b0;
    rx_valid      = 1'b0;
    case (bus_state)
      BUS_INIT: begin
        if (armed) begin
          avm_write   = 1'b1;
          avm_address = ADDR_CTRL;
          bus_next    = BUS_RD_CTRL;
        end
      end
      BUS_RD_CTRL: begin
        avm_read    = 1'b1;
        avm_address = ADDR_CTRL;
        bus_next    = BUS_WAIT_CTRL;
      end
      BUS_WAIT_CTRL: begin
        if (tx_valid && wspace != 16'd0) bus_next = BUS_WR_DATA;
        else if (!cmd_valid)             bus_next = BUS_RD_DATA;
        else                             bus_next = BUS_RD_CTRL;
      end
      BUS_WR_DATA: begin
        avm_write     = 1'b1;
        avm_writedata = {24'h0, tx_data};
        tx_ready      = 1'b1;
        bus_next      = cmd_valid ? BUS_RD_CTRL : BUS_RD_DATA;
      end
      BUS_RD_DATA: begin
        avm_read = 1'b1;
        bus_next = BUS_WAIT_DATA;
      end
      BUS_WAIT_DATA: begin
        rx_valid = avm_readdata[RVALID_BIT];
        bus_next = BUS_RD_CTRL;
      end
      default: bus_next = BUS_INIT;
    endcase
  end

  serial_frame_parser #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .SYNC_BYTE     (SYNC_BYTE)
  ) u_parser (
    .clk       (clk_clk),
    .rst_n     (reset_reset_n),
    .byte_valid(rx_valid),
    .rx_byte   (rx_byte),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_code  (cmd_code),
    .cmd_arg   (cmd_arg),
    .err_count (err_count)
  );

endmodule

// File: tb/tb_serial_cmd_master.sv
// Scoreboard bench for serial_cmd_master: a behavioural UART slave, a
// frame-level reference model and a monitor that checks bus and command traffic.
module tb_serial_cmd_master;

  localparam int         TIMEOUT = 100;
  localparam logic [7:0] SYNC    = 8'hA5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        avm_address;
  logic        avm_chipselect;
  logic [3:0]  avm_byteenable;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata = '0;
  logic [7:0]  tx_data = '0;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic        cmd_valid;
  logic        cmd_ready = 1'b1;
  logic [7:0]  cmd_code;
  logic [15:0] cmd_arg;
  logic [7:0]  err_count;

  serial_cmd_master #(.TIMEOUT_CYCLES(TIMEOUT), .SYNC_BYTE(SYNC)) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .avm_address   (avm_address),
    .avm_chipselect(avm_chipselect),
    .avm_byteenable(avm_byteenable),
    .avm_read      (avm_read),
    .avm_write     (avm_write),
    .avm_writedata (avm_writedata),
    .avm_readdata  (avm_readdata),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_code      (cmd_code),
    .cmd_arg       (cmd_arg),
    .err_count     (err_count)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          cycle = 0;
  int          exp_err = 0;
  int          txn_idx = 0;
  int          tx_writes = 0;
  int          last_data_rd = -100;
  logic [7:0]  rx_q[$];
  logic [23:0] exp_cmd_q[$];
  logic [7:0]  tx_src_q[$];
  logic [7:0]  exp_tx_q[$];
  logic [15:0] wspace = '0;
  logic [15:0] last_wspace = '0;
  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b0;
  logic [23:0] prev_cmd = '0;
  logic [7:0]  slave_byte;
  logic [23:0] exp_word;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  task automatic report_fail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: condition not met", name);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // UART register model: readdata appears the cycle after a read, DATA reads pop the RX FIFO
  always @(posedge clk) begin
    if (!rst_n) begin
      avm_readdata <= '0;
    end else if (avm_read) begin
      if (avm_address) begin
        avm_readdata <= {wspace, 14'($urandom), 2'b00};
        last_wspace  <= wspace;
      end else if (rx_q.size() > 0) begin
        slave_byte    = rx_q.pop_front();
        avm_readdata <= {16'($urandom), 1'b1, 7'($urandom), slave_byte};
      end else begin
        avm_readdata <= {16'($urandom), 1'b0, 15'($urandom)};
      end
    end
  end

  // TX source: presents the head of the byte queue until it is accepted
  initial begin
    forever begin
      @(posedge clk);
      if (tx_valid && tx_ready && tx_src_q.size() > 0) void'(tx_src_q.pop_front());
      #1;
      if (tx_src_q.size() > 0) begin
        tx_valid = 1'b1;
        tx_data  = tx_src_q[0];
      end else begin
        tx_valid = 1'b0;
        tx_data  = '0;
      end
    end
  end

  // Monitor: bus protocol, TX writes and command delivery against the scoreboard
  always @(negedge clk) begin
    cycle++;
    if (!rst_n) begin
      txn_idx    = 0;
      prev_valid = 1'b0;
      prev_ready = 1'b0;
    end else begin
      if (avm_read || avm_write) begin
        check_output("one_strobe", 32'(avm_read & avm_write), 0);
        check_output("chipselect", 32'(avm_chipselect), 1);
        check_output("byteenable", 32'(avm_byteenable), 32'hF);
        if (txn_idx == 0) begin
          check_output("init_is_write", 32'(avm_write), 1);
          check_output("init_addr", 32'(avm_address), 1);
          check_output("init_data", avm_writedata, 0);
        end else if (txn_idx == 1) begin
          check_output("first_poll_read", 32'(avm_read), 1);
          check_output("first_poll_addr", 32'(avm_address), 1);
        end else if (avm_write) begin
          tx_writes++;
          check_output("tx_addr", 32'(avm_address), 0);
          check_output("tx_ready_with_write", 32'(tx_ready), 1);
          check_output("tx_valid_at_write", 32'(tx_valid), 1);
          check_output("tx_wspace_nonzero", 32'(last_wspace != 16'd0), 1);
          if (exp_tx_q.size() == 0) report_fail("tx_unexpected_write");
          else check_output("tx_data", avm_writedata, {24'h0, exp_tx_q.pop_front()});
        end
        if (avm_read && !avm_address) begin
          check_output("no_pop_while_cmd_held", 32'(cmd_valid), 0);
          last_data_rd = cycle;
        end
        txn_idx++;
      end else begin
        check_output("chipselect_idle", 32'(avm_chipselect), 0);
      end
      if (tx_ready && !avm_write) report_fail("tx_ready_without_write");
      if (prev_valid && !prev_ready) begin
        check_output("cmd_hold_valid", 32'(cmd_valid), 1);
        check_output("cmd_hold_data", {8'h0, cmd_code, cmd_arg}, {8'h0, prev_cmd});
      end else if (prev_valid && prev_ready) begin
        check_output("cmd_clear_after_accept", 32'(cmd_valid), 0);
      end else if (cmd_valid) begin
        check_output("cmd_latency", cycle - last_data_rd, 2);
      end
      if (cmd_valid && cmd_ready) begin
        if (exp_cmd_q.size() == 0) begin
          report_fail("cmd_unexpected");
        end else begin
          exp_word = exp_cmd_q.pop_front();
          check_output("cmd_word", {8'h0, cmd_code, cmd_arg}, {8'h0, exp_word});
        end
      end
      prev_valid = cmd_valid;
      prev_ready = cmd_ready;
      prev_cmd   = {cmd_code, cmd_arg};
    end
  end

  task automatic push_frame(input logic [7:0] code, input logic [15:0] arg, input bit good);
    logic [7:0] chk;
    chk = code ^ arg[15:8] ^ arg[7:0];
    if (!good) chk = chk ^ 8'($urandom_range(1, 255));
    rx_q.push_back(SYNC);
    rx_q.push_back(code);
    rx_q.push_back(arg[15:8]);
    rx_q.push_back(arg[7:0]);
    rx_q.push_back(chk);
    if (good) exp_cmd_q.push_back({code, arg});
    else if (exp_err < 255) exp_err++;
  endtask

  task automatic push_tx(input logic [7:0] b);
    tx_src_q.push_back(b);
    exp_tx_q.push_back(b);
  endtask

  task automatic wait_rx_empty(input string name, input int limit);
    int n = 0;
    while (rx_q.size() > 0 && n < limit) begin
      tick(1);
      n++;
    end
    if (rx_q.size() > 0) report_fail(name);
  endtask

  task automatic wait_idle(input string name, input int limit);
    int n = 0;
    while ((rx_q.size() > 0 || exp_cmd_q.size() > 0 || tx_src_q.size() > 0) && n < limit) begin
      tick(1);
      n++;
    end
    if (n >= limit) report_fail(name);
    tick(8);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rx_q.delete();
    exp_cmd_q.delete();
    tx_src_q.delete();
    exp_tx_q.delete();
    exp_err = 0;
    #2;
    check_output("rst_strobes", {28'h0, avm_read, avm_write, avm_chipselect, tx_ready}, 0);
    check_output("rst_addr", 32'(avm_address), 0);
    check_output("rst_writedata", avm_writedata, 0);
    check_output("rst_cmd", {7'h0, cmd_valid, cmd_code, cmd_arg}, 0);
    check_output("rst_err", 32'(err_count), 0);
    tick(3);
    rst_n = 1'b1;
  endtask

  // Randomized mix of good/bad frames, noise, TX bytes, backpressure and WSPACE
  task automatic apply_stimulus(input int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(0, 3))
        0, 1: push_frame(8'($urandom), 16'($urandom), $urandom_range(0, 3) != 0);
        2: repeat ($urandom_range(1, 4)) begin
          b = 8'($urandom);
          if (b == SYNC) b = 8'h00;
          rx_q.push_back(b);
        end
        default: repeat ($urandom_range(1, 3)) push_tx(8'($urandom));
      endcase
      cmd_ready = ($urandom_range(0, 3) != 0);
      wspace    = 16'($urandom_range(0, 2));
      tick($urandom_range(1, 40));
    end
  endtask

  // Directed scenarios followed by random traffic
  initial begin
    int base;
    do_reset();
    tick(20);
    check_output("cmd_valid_idle", 32'(cmd_valid), 0);

    rx_q.push_back(8'hA5); rx_q.push_back(8'h10); rx_q.push_back(8'h12);
    rx_q.push_back(8'h34); rx_q.push_back(8'h36);
    exp_cmd_q.push_back(24'h101234);
    wait_idle("good_frame_drain", 400);
    check_output("good_frame_err", 32'(err_count), 0);

    rx_q.push_back(8'hA5); rx_q.push_back(8'h10); rx_q.push_back(8'h12);
    rx_q.push_back(8'h34); rx_q.push_back(8'h00);
    exp_err = 1;
    wait_idle("bad_frame_drain", 400);
    check_output("bad_frame_err", 32'(err_count), 1);
    push_frame(8'h22, 16'hBEEF, 1'b1);
    wait_idle("after_bad_drain", 400);
    check_output("after_bad_err", 32'(err_count), 1);

    rx_q.push_back(SYNC); rx_q.push_back(8'h10);
    wait_rx_empty("timeout_rx", 400);
    tick(3 * TIMEOUT);
    exp_err++;
    check_output("timeout_err", 32'(err_count), 32'(exp_err));
    push_frame(8'h5A, 16'hA5A5, 1'b1);
    wait_idle("after_timeout_drain", 400);
    check_output("after_timeout_err", 32'(err_count), 32'(exp_err));

    cmd_ready = 1'b0;
    push_frame(8'h01, 16'h0203, 1'b1);
    push_frame(8'h04, 16'h0506, 1'b1);
    base = 0;
    while (rx_q.size() > 5 && base < 400) begin tick(1); base++; end
    tick(100);
    check_output("bp_second_frame_unread", rx_q.size(), 5);
    check_output("bp_cmd_held", 32'(cmd_valid), 1);
    cmd_ready = 1'b1;
    wait_idle("bp_drain", 800);

    wspace = 16'd0;
    base = tx_writes;
    push_tx(8'h41);
    push_tx(8'h42);
    tick(60);
    check_output("tx_blocked_no_space", tx_writes - base, 0);
    wspace = 16'd1;
    wait_idle("tx_drain", 400);
    check_output("tx_write_count", tx_writes - base, 2);

    apply_stimulus(60);
    cmd_ready = 1'b1;
    wspace    = 16'd4;
    wait_idle("random_drain", 10000);
    check_output("random_err", 32'(err_count), 32'(exp_err));

    rx_q.push_back(SYNC); rx_q.push_back(8'h10); rx_q.push_back(8'h12);
    wait_rx_empty("midframe_rx", 400);
    tick(2);
    do_reset();
    tick(10);
    push_frame(8'h77, 16'h1357, 1'b1);
    wait_idle("post_reset_drain", 400);
    check_output("post_reset_err", 32'(err_count), 0);

    for (int i = 0; i < 260; i++) push_frame(8'($urandom), 16'($urandom), 1'b0);
    wait_idle("saturate_drain", 20000);
    check_output("err_saturated", 32'(err_count), 32'hFF);

    check_output("cmd_queue_empty", exp_cmd_q.size(), 0);
    check_output("tx_queue_empty", exp_tx_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog so the bench always terminates
  initial begin
    #600000;
    $display("[TB] FAIL global_timeout: simulation did not complete");
    $display("CHECKS %0d ERRORS %0d", checks + 1, errors + 1);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
